// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: default widths and the command encodings
// for the arithmetic and logical modes.
package alu_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CMD_WIDTH  = 4;

    typedef enum logic [DEF_CMD_WIDTH-1:0] {
        ADD,
        SUB,
        ADD_CIN,
        SUB_CIN,
        INC_A,
        DEC_A,
        INC_B,
        DEC_B,
        CMP
    } arith_cmd_e;

    typedef enum logic [DEF_CMD_WIDTH-1:0] {
        AND,
        NAND,
        OR,
        NOR,
        XOR,
        XNOR,
        NOT_A,
        NOT_B,
        SHR1_A,
        SHL1_A,
        SHR1_B,
        SHL1_B,
        ROL_A_B,
        ROR_A_B
    } logic_cmd_e;

endpackage

// File: rtl/alu_comb.sv
// Purely combinational ALU core: decodes mode/cmd, checks operand validity and
// produces the next result and flag values.
module alu_comb
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CMD_WIDTH  = DEF_CMD_WIDTH
) (
    input  logic                  mode,
    input  logic [CMD_WIDTH-1:0]  cmd,
    input  logic [1:0]            inp_valid,
    input  logic [DATA_WIDTH-1:0] opa,
    input  logic [DATA_WIDTH-1:0] opb,
    input  logic                  cin,
    output logic [DATA_WIDTH:0]   res,
    output logic                  cout,
    output logic                  oflow,
    output logic                  g,
    output logic                  l,
    output logic                  e,
    output logic                  err
);

    localparam int SH_W = $clog2(DATA_WIDTH);
    localparam logic [SH_W:0] W_AMT = (SH_W + 1)'(DATA_WIDTH);

    logic [DATA_WIDTH:0]   a_ext;
    logic [DATA_WIDTH:0]   b_ext;
    logic [DATA_WIDTH:0]   cin_ext;
    logic [DATA_WIDTH:0]   one_ext;
    logic [SH_W-1:0]       rot_amt;
    logic [SH_W:0]         rot_comp;
    logic                  rot_too_big;
    logic [DATA_WIDTH-1:0] rol_val;
    logic [DATA_WIDTH-1:0] ror_val;
    logic                  legal;
    logic                  need_a;
    logic                  need_b;
    logic                  operands_ok;

    assign a_ext   = {1'b0, opa};
    assign b_ext   = {1'b0, opb};
    assign cin_ext = {{DATA_WIDTH{1'b0}}, cin};
    assign one_ext = {{DATA_WIDTH{1'b0}}, 1'b1};

    // Only the low log2(W) bits of opb are a rotate amount; anything above flags an error.
    assign rot_amt     = opb[SH_W-1:0];
    assign rot_comp    = W_AMT - {1'b0, rot_amt};
    assign rot_too_big = |opb[DATA_WIDTH-1:SH_W];
    assign rol_val     = (opa << rot_amt) | (opa >> rot_comp);
    assign ror_val     = (opa >> rot_amt) | (opa << rot_comp);

    always_comb begin
        legal  = 1'b0;
        need_a = 1'b0;
        need_b = 1'b0;
        if (mode) begin
            case (cmd)
                ADD, SUB, ADD_CIN, SUB_CIN, CMP: begin
                    legal  = 1'b1;
                    need_a = 1'b1;
                    need_b = 1'b1;
                end
                INC_A, DEC_A: begin
                    legal  = 1'b1;
                    need_a = 1'b1;
                end
                INC_B, DEC_B: begin
                    legal  = 1'b1;
                    need_b = 1'b1;
                end
                default: ;
            endcase
        end else begin
            case (cmd)
                AND, NAND, OR, NOR, XOR, XNOR, ROL_A_B, ROR_A_B: begin
                    legal  = 1'b1;
                    need_a = 1'b1;
                    need_b = 1'b1;
                end
                NOT_A, SHR1_A, SHL1_A: begin
                    legal  = 1'b1;
                    need_a = 1'b1;
                end
                NOT_B, SHR1_B, SHL1_B: begin
                    legal  = 1'b1;
                    need_b = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign operands_ok = legal && (!need_a || inp_valid[0]) && (!need_b || inp_valid[1]);

    always_comb begin
        res   = '0;
        cout  = 1'b0;
        oflow = 1'b0;
        g     = 1'b0;
        l     = 1'b0;
        e     = 1'b0;
        err   = 1'b0;
        if (!operands_ok) begin
            err = 1'b1;
        end else if (mode) begin
            case (cmd)
                ADD: begin
                    res  = a_ext + b_ext;
                    cout = res[DATA_WIDTH];
                end
                SUB: begin
                    res   = a_ext - b_ext;
                    oflow = (b_ext > a_ext);
                end
                ADD_CIN: begin
                    res  = a_ext + b_ext + cin_ext;
                    cout = res[DATA_WIDTH];
                end
                SUB_CIN: begin
                    res   = a_ext - b_ext - cin_ext;
                    oflow = ((b_ext + cin_ext) > a_ext);
                end
                INC_A: begin
                    res  = a_ext + one_ext;
                    cout = res[DATA_WIDTH];
                end
                DEC_A: begin
                    res   = a_ext - one_ext;
                    oflow = (opa == '0);
                end
                INC_B: begin
                    res  = b_ext + one_ext;
                    cout = res[DATA_WIDTH];
                end
                DEC_B: begin
                    res   = b_ext - one_ext;
                    oflow = (opb == '0);
                end
                CMP: begin
                    g = (opa > opb);
                    l = (opa < opb);
                    e = (opa == opb);
                end
                default: ;
            endcase
        end else begin
            case (cmd)
                AND:     res = {1'b0, opa & opb};
                NAND:    res = {1'b0, ~(opa & opb)};
                OR:      res = {1'b0, opa | opb};
                NOR:     res = {1'b0, ~(opa | opb)};
                XOR:     res = {1'b0, opa ^ opb};
                XNOR:    res = {1'b0, ~(opa ^ opb)};
                NOT_A:   res = {1'b0, ~opa};
                NOT_B:   res = {1'b0, ~opb};
                SHR1_A:  res = {2'b00, opa[DATA_WIDTH-1:1]};
                SHL1_A:  res = {1'b0, opa[DATA_WIDTH-2:0], 1'b0};
                SHR1_B:  res = {2'b00, opb[DATA_WIDTH-1:1]};
                SHL1_B:  res = {1'b0, opb[DATA_WIDTH-2:0], 1'b0};
                ROL_A_B: begin
                    res = {1'b0, rol_val};
                    err = rot_too_big;
                end
                ROR_A_B: begin
                    res = {1'b0, ror_val};
                    err = rot_too_big;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu.sv
// Registered ALU top: the combinational core feeds a clock-enabled output register
// that clears asynchronously on reset.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CMD_WIDTH  = DEF_CMD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  mode,
    input  logic [CMD_WIDTH-1:0]  cmd,
    input  logic [1:0]            inp_valid,
    input  logic [DATA_WIDTH-1:0] opa,
    input  logic [DATA_WIDTH-1:0] opb,
    input  logic                  cin,
    output logic [DATA_WIDTH:0]   res,
    output logic                  cout,
    output logic                  oflow,
    output logic                  g,
    output logic                  l,
    output logic                  e,
    output logic                  err
);

    logic [DATA_WIDTH:0] comb_res;
    logic                comb_cout;
    logic                comb_oflow;
    logic                comb_g;
    logic                comb_l;
    logic                comb_e;
    logic                comb_err;

    logic [DATA_WIDTH:0] res_d,   res_q;
    logic                cout_d,  cout_q;
    logic                oflow_d, oflow_q;
    logic                g_d,     g_q;
    logic                l_d,     l_q;
    logic                e_d,     e_q;
    logic                err_d,   err_q;

    alu_comb #(
        .DATA_WIDTH (DATA_WIDTH),
        .CMD_WIDTH  (CMD_WIDTH)
    ) u_comb (
        .mode      (mode),
        .cmd       (cmd),
        .inp_valid (inp_valid),
        .opa       (opa),
        .opb       (opb),
        .cin       (cin),
        .res       (comb_res),
        .cout      (comb_cout),
        .oflow     (comb_oflow),
        .g         (comb_g),
        .l         (comb_l),
        .e         (comb_e),
        .err       (comb_err)
    );

    always_comb begin
        res_d   = res_q;
        cout_d  = cout_q;
        oflow_d = oflow_q;
        g_d     = g_q;
        l_d     = l_q;
        e_d     = e_q;
        err_d   = err_q;
        if (ce) begin
            res_d   = comb_res;
            cout_d  = comb_cout;
            oflow_d = comb_oflow;
            g_d     = comb_g;
            l_d     = comb_l;
            e_d     = comb_e;
            err_d   = comb_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= '0;
            cout_q  <= 1'b0;
            oflow_q <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            res_q   <= res_d;
            cout_q  <= cout_d;
            oflow_q <= oflow_d;
            g_q     <= g_d;
            l_q     <= l_d;
            e_q     <= e_d;
            err_q   <= err_d;
        end
    end

    assign res   = res_q;
    assign cout  = cout_q;
    assign oflow = oflow_q;
    assign g     = g_q;
    assign l     = l_q;
    assign e     = e_q;
    assign err   = err_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the registered ALU: directed corner cases plus a random run
// compared against an integer-arithmetic reference model.
module tb_alu;

    logic       clk;
    logic       rst;
    logic       ce;
    logic       mode;
    logic [3:0] cmd;
    logic [1:0] inp_valid;
    logic [7:0] opa;
    logic [7:0] opb;
    logic       cin;
    logic [8:0] res;
    logic       cout;
    logic       oflow;
    logic       g;
    logic       l;
    logic       e;
    logic       err;

    logic [14:0] dut_vec;
    logic [14:0] exp_vec;
    int          checks;
    int          errors;

    assign dut_vec = {res, cout, oflow, g, l, e, err};

    alu dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .mode      (mode),
        .cmd       (cmd),
        .inp_valid (inp_valid),
        .opa       (opa),
        .opb       (opb),
        .cin       (cin),
        .res       (res),
        .cout      (cout),
        .oflow     (oflow),
        .g         (g),
        .l         (l),
        .e         (e),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected {res, cout, oflow, g, l, e, err} from plain integer arithmetic.
    function automatic logic [14:0] model(input logic m, input logic [3:0] c, input logic [1:0] iv,
                                          input logic [7:0] a, input logic [7:0] b, input logic ci);
        int  ai;
        int  bi;
        int  r;
        int  amt;
        bit  legal;
        bit  need_a;
        bit  need_b;
        bit  fc;
        bit  fo;
        bit  fg;
        bit  fl;
        bit  fe;
        bit  fr;
        ai = int'(a);
        bi = int'(b);
        r  = 0;
        fc = 0; fo = 0; fg = 0; fl = 0; fe = 0; fr = 0;
        if (m) begin
            legal  = (c <= 4'd8);
            need_a = (c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8});
            need_b = (c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8});
        end else begin
            legal  = (c <= 4'd13);
            need_a = (c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd12, 4'd13});
            need_b = (c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd10, 4'd11, 4'd12, 4'd13});
        end
        if (!legal || (need_a && !iv[0]) || (need_b && !iv[1])) return {9'd0, 6'b000001};
        if (m) begin
            case (c)
                4'd0: begin r = ai + bi;      fc = (r > 255); end
                4'd1: begin r = ai - bi;      fo = (r < 0);   end
                4'd2: begin r = ai + bi + ci; fc = (r > 255); end
                4'd3: begin r = ai - bi - ci; fo = (r < 0);   end
                4'd4: begin r = ai + 1;       fc = (r > 255); end
                4'd5: begin r = ai - 1;       fo = (r < 0);   end
                4'd6: begin r = bi + 1;       fc = (r > 255); end
                4'd7: begin r = bi - 1;       fo = (r < 0);   end
                default: begin
                    r  = 0;
                    fg = (ai > bi);
                    fl = (ai < bi);
                    fe = (ai == bi);
                end
            endcase
        end else begin
            case (c)
                4'd0:  r = ai & bi;
                4'd1:  r = 255 - (ai & bi);
                4'd2:  r = ai | bi;
                4'd3:  r = 255 - (ai | bi);
                4'd4:  r = ai ^ bi;
                4'd5:  r = 255 - (ai ^ bi);
                4'd6:  r = 255 - ai;
                4'd7:  r = 255 - bi;
                4'd8:  r = ai / 2;
                4'd9:  r = (ai * 2) % 256;
                4'd10: r = bi / 2;
                4'd11: r = (bi * 2) % 256;
                default: begin
                    amt = bi % 8;
                    fr  = (bi >= 8);
                    r   = ai;
                    for (int k = 0; k < amt; k++) begin
                        if (c == 4'd12) r = ((r * 2) % 256) + (r / 128);
                        else            r = (r / 2) + ((r % 2) * 128);
                    end
                end
            endcase
        end
        return {9'(r), fc, fo, fg, fl, fe, fr};
    endfunction

    task automatic applyStimulus(input logic m, input logic [3:0] c, input logic [1:0] iv,
                                 input logic [7:0] a, input logic [7:0] b, input logic ci,
                                 input logic ce_v);
        mode      = m;
        cmd       = c;
        inp_valid = iv;
        opa       = a;
        opb       = b;
        cin       = ci;
        ce        = ce_v;
        @(posedge clk);
        if (ce_v) exp_vec = model(m, c, iv, a, b, ci);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (dut_vec === exp_vec)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, dut_vec, exp_vec);
        end
    endtask

    task automatic checkConst(input string tag, input logic [14:0] want);
        checks++;
        assert (dut_vec === want)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, dut_vec, want);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       rm;
        logic [3:0] rc;
        logic [1:0] riv;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rci;
        logic       rce;

        checks    = 0;
        errors    = 0;
        exp_vec   = '0;
        rst       = 1'b1;
        ce        = 1'b0;
        mode      = 1'b0;
        cmd       = 4'd0;
        inp_valid = 2'b00;
        opa       = 8'h00;
        opb       = 8'h00;
        cin       = 1'b0;

        #12;
        checkConst("reset_state", 15'd0);
        rst = 1'b0;

        applyStimulus(1'b1, 4'd0, 2'b11, 8'hFF, 8'h01, 1'b0, 1'b1);
        checkConst("add_carry", {9'h100, 6'b100000});
        applyStimulus(1'b1, 4'd1, 2'b11, 8'h03, 8'h05, 1'b0, 1'b1);
        checkConst("sub_borrow", {9'h1FE, 6'b010000});
        applyStimulus(1'b1, 4'd8, 2'b11, 8'h10, 8'h10, 1'b0, 1'b1);
        checkConst("cmp_equal", {9'h000, 6'b000010});
        applyStimulus(1'b1, 4'd8, 2'b11, 8'h20, 8'h10, 1'b0, 1'b1);
        checkConst("cmp_greater", {9'h000, 6'b001000});
        applyStimulus(1'b1, 4'd8, 2'b11, 8'h05, 8'h90, 1'b0, 1'b1);
        checkConst("cmp_less", {9'h000, 6'b000100});
        applyStimulus(1'b0, 4'd12, 2'b11, 8'h81, 8'h01, 1'b0, 1'b1);
        checkConst("rol_ok", {9'h003, 6'b000000});
        applyStimulus(1'b0, 4'd12, 2'b11, 8'h81, 8'h09, 1'b0, 1'b1);
        checkConst("rol_amt_err", {9'h003, 6'b000001});
        applyStimulus(1'b0, 4'd13, 2'b11, 8'h81, 8'h02, 1'b0, 1'b1);
        checkConst("ror_ok", {9'h060, 6'b000000});
        applyStimulus(1'b1, 4'd0, 2'b01, 8'h12, 8'h34, 1'b0, 1'b1);
        checkConst("add_missing_b", {9'h000, 6'b000001});
        applyStimulus(1'b0, 4'd14, 2'b11, 8'h12, 8'h34, 1'b0, 1'b1);
        checkConst("logic_illegal", {9'h000, 6'b000001});
        applyStimulus(1'b1, 4'd9, 2'b11, 8'h12, 8'h34, 1'b0, 1'b1);
        checkConst("arith_illegal", {9'h000, 6'b000001});
        applyStimulus(1'b0, 4'd6, 2'b00, 8'h12, 8'h34, 1'b0, 1'b1);
        checkConst("iv_none", {9'h000, 6'b000001});
        applyStimulus(1'b1, 4'd4, 2'b01, 8'hFF, 8'h00, 1'b1, 1'b1);
        checkConst("inc_a_wrap", {9'h100, 6'b100000});
        applyStimulus(1'b1, 4'd5, 2'b01, 8'h00, 8'h77, 1'b1, 1'b1);
        checkConst("dec_a_wrap", {9'h1FF, 6'b010000});
        applyStimulus(1'b1, 4'd2, 2'b11, 8'hFE, 8'h01, 1'b1, 1'b1);
        checkConst("add_cin", {9'h100, 6'b100000});
        applyStimulus(1'b1, 4'd3, 2'b11, 8'h05, 8'h05, 1'b1, 1'b1);
        checkConst("sub_cin_borrow", {9'h1FF, 6'b010000});
        applyStimulus(1'b1, 4'd0, 2'b11, 8'h10, 8'h20, 1'b1, 1'b1);
        checkConst("add_ignores_cin", {9'h030, 6'b000000});
        applyStimulus(1'b1, 4'd6, 2'b10, 8'h00, 8'h41, 1'b0, 1'b1);
        checkConst("inc_b_only_b", {9'h042, 6'b000000});

        // Clock enable low: outputs must hold through three edges of changing inputs.
        applyStimulus(1'b0, 4'd4, 2'b11, 8'hF0, 8'h3C, 1'b0, 1'b1);
        checkConst("xor_before_hold", {9'h0CC, 6'b000000});
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'(i), 2'b11, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
            checkConst("ce_hold", {9'h0CC, 6'b000000});
        end
        applyStimulus(1'b1, 4'd0, 2'b11, 8'h01, 8'h02, 1'b0, 1'b1);
        checkConst("ce_resume", {9'h003, 6'b000000});

        // Asynchronous reset between edges, then resume on the next enabled edge.
        #2;
        rst = 1'b1;
        #1;
        exp_vec = '0;
        checkConst("async_reset", 15'd0);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 4'd2, 2'b11, 8'hA0, 8'h05, 1'b0, 1'b1);
        checkConst("after_reset", {9'h0A5, 6'b000000});

        for (int i = 0; i < 400; i++) begin
            rm  = 1'($urandom_range(0, 1));
            rc  = 4'($urandom_range(0, 15));
            riv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            case ($urandom_range(0, 3))
                0:       ra = 8'h00;
                1:       ra = 8'hFF;
                default: ra = 8'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       rb = 8'($urandom_range(0, 7));
                1:       rb = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
                default: rb = 8'($urandom);
            endcase
            rci = 1'($urandom_range(0, 1));
            rce = ($urandom_range(0, 7) != 0);
            applyStimulus(rm, rc, riv, ra, rb, rci, rce);
            checkOutput("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
